de_morgan_sweep_ctrl: RTL and testbench
=======================================

DE_MORGAN_SWEEP_CTRL -- requirements
Module: de_morgan_sweep_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and rst_n.
REQ-002 Parameter SETTLE SHALL default to 2 and set the cycles each input vector is held before sampling; legal range 1..15.
REQ-003 Port clk SHALL be: input, 1 bit, system clock.
REQ-004 Port rst_n SHALL be: input, 1 bit, asynchronous active-low reset.
REQ-005 Port start SHALL be: input, 1 bit, sweep request, sampled only in IDLE.
REQ-006 Port c_in SHALL be: input, 1 bit, output of the gate under test, form ~a&~b.
REQ-007 Port d_in SHALL be: input, 1 bit, output of the gate under test, form ~(a|b).
REQ-008 Port a_out SHALL be: output, 1 bit, drives gate input a.
REQ-009 Port b_out SHALL be: output, 1 bit, drives gate input b.
REQ-010 Port busy SHALL be: output, 1 bit, high in every state except IDLE.
REQ-011 Port done SHALL be: output, 1 bit, one-cycle pulse at sweep end.
REQ-012 Port pass SHALL be: output, 1 bit, sweep result; held until the next accepted start.
REQ-013 Port err_cnt SHALL be: output, 3 bits, number of failing vectors (0..4).
REQ-014 Port fail_idx SHALL be: output, 2 bits, vector index {a,b} of the first failure; valid only when err_cnt != 0.

Function
REQ-015 The FSM SHALL have states IDLE, DRIVE, SAMPLE and DONE.
REQ-016 In IDLE, start=1 SHALL cause DRIVE on the next edge, set idx=0, and clear err_cnt, fail_idx, pass and the settle counter.
REQ-017 In DRIVE and SAMPLE, a_out SHALL equal idx[1] and b_out SHALL equal idx[0]; in IDLE and DONE, both SHALL be 0.
REQ-018 DRIVE SHALL last exactly SETTLE cycles, counted by a settle counter from 0 to SETTLE-1, then go to SAMPLE.
REQ-019 SAMPLE SHALL last one cycle and compute expected = ~idx[1] & ~idx[0].
REQ-020 A vector SHALL fail if c_in != expected or d_in != expected.
REQ-021 On each failing vector, err_cnt SHALL increment by one.
REQ-022 fail_idx SHALL latch idx only when err_cnt is 0 before the increment, so it records the first failure only.
REQ-023 After SAMPLE, if idx == 3 the FSM SHALL go to DONE; otherwise it SHALL increment idx and return to DRIVE.
REQ-024 No counter SHALL wrap: idx is never incremented past 3, and err_cnt never exceeds 4.
REQ-025 In DONE, done SHALL be 1 for exactly one cycle, pass SHALL be set to (err_cnt == 0), and the FSM SHALL return to IDLE on the next edge.
REQ-026 Latency SHALL be fixed: if start is sampled at edge k, done SHALL be high in the cycle after edge k+1+4*(SETTLE+1) (k+13 for SETTLE=2).
REQ-027 start SHALL be ignored while busy=1, with no effect on idx or the counters.
REQ-028 start held high continuously SHALL begin a new sweep in the first IDLE cycle after DONE.
REQ-029 c_in and d_in SHALL be sampled only in SAMPLE; their values in other states SHALL have no effect.

Reset
REQ-030 When rst_n=0, the block SHALL asynchronously enter IDLE.
REQ-031 When rst_n=0, all of the following SHALL be 0 asynchronously: idx, settle counter, err_cnt, fail_idx, pass, done, busy, a_out and b_out.
REQ-032 Reset asserted mid-sweep SHALL abort the sweep with no done pulse.
REQ-033 After rst_n is released, the block SHALL need a new start before any sweep runs.

Structure
REQ-034 Shared package de_morgan_pkg SHALL hold the state encodings, NUM_VECTORS=4, and the index and error-count widths.
REQ-035 The settle counter SHALL be the one sub-module, settle_counter: load/clear, count-enable, and a terminal-count flag at SETTLE-1.
REQ-036 The expected-value logic SHALL be inline in de_morgan_sweep_ctrl, not a separate module.

Verification
REQ-037 Good gate (c_in=d_in=~a&~b), SETTLE=2, one start pulse -> a_out,b_out step 00,01,10,11 with 3 cycles each; done at k+13; pass=1, err_cnt=0.
REQ-038 d_in stuck at 0 -> vector 00 fails; err_cnt=1, fail_idx=0, pass=0.
REQ-039 c_in stuck at 1 -> vectors 01,10,11 fail; err_cnt=3, fail_idx=1, pass=0.
REQ-040 rst_n low during vector 10 -> all outputs 0 immediately and no done pulse; a following start gives a full clean sweep with pass=1.
REQ-041 start pulsed mid-sweep and start held high across DONE -> no effect mid-sweep; a second sweep begins right after DONE, and pass/err_cnt are cleared at its start.

Source files
------------

// File: rtl/de_morgan_pkg.sv
// Shared types and sizes for the De Morgan gate sweep controller.
// State encodings, vector count and counter widths.
package de_morgan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int NUM_VECTORS = 4;
  localparam int IDX_W       = 2;
  localparam int ERR_W       = 3;
  localparam int CNT_W       = 4;

endpackage

// File: rtl/de_morgan_sweep_ctrl_settle_counter.sv
// Settle-time counter: counts 0..SETTLE-1 while enabled.
// Flags the terminal count and wraps to 0 on it.
module settle_counter
  import de_morgan_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      if (tc) cnt <= '0;
      else    cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/de_morgan_sweep_ctrl.sv
// Drives all four {a,b} vectors into a NOR-form gate pair and
// checks both outputs against ~a&~b, reporting pass/err/first fail.
module de_morgan_sweep_ctrl
  import de_morgan_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             c_in,
  input  logic             d_in,
  output logic             a_out,
  output logic             b_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [IDX_W-1:0] fail_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0] MAX_ERR  = ERR_W'(NUM_VECTORS);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic             settle_tc;
  logic             expect_v;
  logic             vec_fail;

  assign idx_nxt  = idx + 1'b1;
  assign expect_v = ~idx[1] & ~idx[0];
  assign vec_fail = (c_in != expect_v) | (d_in != expect_v);

  settle_counter #(.SETTLE(SETTLE)) u_settle (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (state == IDLE),
    .en    (state == DRIVE),
    .tc    (settle_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      idx      <= '0;
      err_cnt  <= '0;
      fail_idx <= '0;
      pass     <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      a_out    <= 1'b0;
      b_out    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= DRIVE;
            idx      <= '0;
            err_cnt  <= '0;
            fail_idx <= '0;
            pass     <= 1'b0;
            busy     <= 1'b1;
            a_out    <= 1'b0;
            b_out    <= 1'b0;
          end
        end
        DRIVE: begin
          if (settle_tc) state <= SAMPLE;
        end
        SAMPLE: begin
          if (vec_fail && err_cnt != MAX_ERR) begin
            if (err_cnt == '0) fail_idx <= idx;
            err_cnt <= err_cnt + 1'b1;
          end
          if (idx == LAST_IDX) begin
            state <= DONE;
            a_out <= 1'b0;
            b_out <= 1'b0;
          end else begin
            state <= DRIVE;
            idx   <= idx_nxt;
            a_out <= idx_nxt[1];
            b_out <= idx_nxt[0];
          end
        end
        DONE: begin
          done  <= 1'b1;
          pass  <= (err_cnt == '0);
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_de_morgan_sweep_ctrl.sv
// Directed bench for de_morgan_sweep_ctrl with a behavioural gate
// model that can inject stuck-at faults on c_in / d_in.
module tb_de_morgan_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       c_in;
  logic       d_in;
  logic       a_out;
  logic       b_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_cnt;
  logic [1:0] fail_idx;

  int checks = 0;
  int errors = 0;
  int mode = 0;

  always #5 clk = ~clk;

  assign c_in = (mode == 2) ? 1'b1 : (~a_out & ~b_out);
  assign d_in = (mode == 1) ? 1'b0 : (~a_out & ~b_out);

  de_morgan_sweep_ctrl #(.SETTLE(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .c_in     (c_in),
    .d_in     (d_in),
    .a_out    (a_out),
    .b_out    (b_out),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_cnt  (err_cnt),
    .fail_idx (fail_idx)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start; returns at the negedge of the first DRIVE cycle.
  task automatic do_start(input bit hold);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  // Walks one sweep from the first DRIVE cycle through the done cycle.
  task automatic sweep_body(input logic exp_pass, input logic [2:0] exp_err,
                            input logic [1:0] exp_fidx);
    logic [1:0] v;
    for (int j = 0; j < 14; j++) begin
      if (j < 12) begin
        v = 2'(j / 3);
        chk("vec", {12'd0, busy, done, a_out, b_out}, {12'd0, 2'b10, v});
      end else if (j == 12) begin
        chk("donestate", {12'd0, busy, done, a_out, b_out}, 16'h0008);
      end else begin
        chk("donepulse", {12'd0, busy, done, a_out, b_out}, 16'h0004);
        chk("pass", {15'd0, pass}, {15'd0, exp_pass});
        chk("err_cnt", {13'd0, err_cnt}, {13'd0, exp_err});
        if (exp_err != 3'd0)
          chk("fail_idx", {14'd0, fail_idx}, {14'd0, exp_fidx});
      end
      if (j < 13) @(negedge clk);
    end
  endtask

  initial begin
    // reset state
    #12;
    chk("reset", {6'd0, busy, done, pass, a_out, b_out, err_cnt, fail_idx},
        16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle", {12'd0, busy, done, a_out, b_out}, 16'h0000);

    // good gate
    mode = 0;
    do_start(1'b0);
    sweep_body(1'b1, 3'd0, 2'd0);
    @(negedge clk);
    chk("done_one_cycle", {15'd0, done}, 16'h0000);
    chk("pass_held", {15'd0, pass}, 16'h0001);

    // d_in stuck at 0
    mode = 1;
    do_start(1'b0);
    sweep_body(1'b0, 3'd1, 2'd0);

    // c_in stuck at 1
    mode = 2;
    do_start(1'b0);
    sweep_body(1'b0, 3'd3, 2'd1);

    // reset during vector 10
    mode = 1;
    do_start(1'b0);
    for (int i = 0; i < 6; i++) @(negedge clk);
    chk("pre_rst_vec", {12'd0, busy, a_out, b_out, 1'b0}, 16'h000c);
    chk("pre_rst_err", {13'd0, err_cnt}, 16'h0001);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {6'd0, busy, done, pass, a_out, b_out, err_cnt,
        fail_idx}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {14'd0, busy, done}, 16'h0000);
    end
    mode = 0;
    do_start(1'b0);
    sweep_body(1'b1, 3'd0, 2'd0);

    // start held high across a sweep and into the next one
    mode = 1;
    do_start(1'b1);
    sweep_body(1'b0, 3'd1, 2'd0);
    mode = 0;
    @(negedge clk);
    chk("restart", {6'd0, busy, done, pass, a_out, b_out, err_cnt, fail_idx},
        16'h0200);
    start = 1'b0;
    @(negedge clk);
    for (int j = 1; j < 14; j++) begin
      if (j < 12)
        chk("vec2", {12'd0, busy, done, a_out, b_out},
            {12'd0, 2'b10, 2'(j / 3)});
      else if (j == 13)
        chk("done2", {12'd0, busy, done, pass, err_cnt == 3'd0}, 16'h0007);
      if (j < 13) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
